// File: rtl/wb_pkg.sv
// Shared Wishbone constants, request payload and responder FSM encoding.
package wb_pkg;

    localparam int unsigned WB_DAT_W   = 32;
    localparam int unsigned WB_ADR_W   = 32;
    localparam int unsigned WB_SEL_W   = 4;
    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_COOL
    } wb_state_e;

    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] addr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
    } wb_req_t;

endpackage

// File: rtl/wb_ram_core.sv
// Word-organised RAM: one byte-enabled synchronous write port, one combinational read port.
module wb_ram_core
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WB_DAT_W-1:0]   wr_data,
    input  logic [WB_SEL_W-1:0]   wr_be,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WB_DAT_W-1:0]   rd_data_c
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WB_DAT_W-1:0] mem [DEPTH];

    // Contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int k = 0; k < int'(WB_SEL_W); k++) begin
                if (wr_be[k]) begin
                    mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic responder in front of an on-chip RAM, with optional
// wait states and range/alignment error termination.
module wb_ram_slave
    import wb_pkg::*;
#(
    parameter int unsigned         DEPTH_LOG2  = 10,
    parameter logic [WB_ADR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned         WAIT_STATES = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [WB_ADR_W-1:0] wbs_addr_i,
    input  logic [WB_DAT_W-1:0] wbs_dat_i,
    input  logic [WB_SEL_W-1:0] wbs_sel_i,
    output logic [WB_DAT_W-1:0] wbs_dat_o,
    output logic                wbs_ack_o,
    output logic                wbs_err_o
);

    localparam int unsigned          OFF_W     = WB_ADR_W + 1;
    localparam logic [OFF_W-1:0]     SPAN      = OFF_W'(4) << DEPTH_LOG2;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_STATES - 1);

    wb_state_e             state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    wb_req_t               req_q, req_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [WB_DAT_W-1:0]   dat_q, dat_d;

    logic [WB_ADR_W-1:0]   off_c;
    logic                  addr_err_c;
    logic                  mem_we_c;
    logic [WB_DAT_W-1:0]   rd_data_c;

    // Offsets below BASE_ADDR wrap to large values and land in the error range.
    assign off_c      = req_q.addr - BASE_ADDR;
    assign addr_err_c = (req_q.addr[1:0] != 2'b00) || ({1'b0, off_c} >= SPAN);

    wb_ram_core #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_core (
        .clk_i     (clk_i),
        .wr_en     (mem_we_c),
        .wr_addr   (off_c[DEPTH_LOG2+1:2]),
        .wr_data   (req_q.dat),
        .wr_be     (req_q.sel),
        .rd_addr   (off_c[DEPTH_LOG2+1:2]),
        .rd_data_c (rd_data_c)
    );

    // State, latched request and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    // Next-state and response decode; RAM write and read capture happen on leaving RESP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = dat_q;
        mem_we_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    req_d   = '{we: wbs_we_i, addr: wbs_addr_i, dat: wbs_dat_i, sel: wbs_sel_i};
                    cnt_d   = '0;
                    state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!(wbs_cyc_i && wbs_stb_i)) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + WAIT_CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_COOL;
                if (addr_err_c) begin
                    err_d = 1'b1;
                    dat_d = '0;
                end else begin
                    ack_d = 1'b1;
                    if (req_q.we) begin
                        mem_we_c = 1'b1;
                    end else begin
                        dat_d = rd_data_c;
                    end
                end
            end
            ST_COOL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign wbs_dat_o = dat_q;
    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: two instances (0 and 3 wait states) checked
// every cycle against a transaction-level scoreboard plus literal read-back values.
module tb_wb_ram_slave;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned DLOG2 = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       cyc, stb, we;
    logic [1:0][31:0] adr, wdat;
    logic [1:0][3:0]  sel;
    wire  [31:0]      rdat0, rdat1;
    wire              ack0, ack1, err0, err1;

    wb_ram_slave #(.DEPTH_LOG2(DLOG2), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]),
        .wbs_addr_i(adr[0]), .wbs_dat_i(wdat[0]), .wbs_sel_i(sel[0]),
        .wbs_dat_o(rdat0), .wbs_ack_o(ack0), .wbs_err_o(err0)
    );

    wb_ram_slave #(.DEPTH_LOG2(DLOG2), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]),
        .wbs_addr_i(adr[1]), .wbs_dat_i(wdat[1]), .wbs_sel_i(sel[1]),
        .wbs_dat_o(rdat1), .wbs_ack_o(ack1), .wbs_err_o(err1)
    );

    typedef struct {
        int          cyc;
        bit          err;
        bit          upd;
        logic [31:0] dat;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] exp_dat [2];
    bit   [31:0] mdl [int];
    int          ncyc  = 0;
    int          nvec  = 0;
    int          nfail = 0;
    logic [31:0] r;

    always @(posedge clk) ncyc <= ncyc + 1;

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] out_dat(input int d);
        return (d == 0) ? rdat0 : rdat1;
    endfunction

    function automatic logic out_ack(input int d);
        return (d == 0) ? ack0 : ack1;
    endfunction

    function automatic logic out_err(input int d);
        return (d == 0) ? err0 : err1;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, ncyc);
        end
    endfunction

    // Error rule: misaligned, or offset from BASE (unsigned, wrapping) beyond the RAM size.
    function automatic bit m_err(input logic [31:0] a);
        longint unsigned off;
        longint unsigned span;
        off  = longint'(a - BASE);
        span = 64'd4 << DLOG2;
        return (a % 4 != 0) || (off >= span);
    endfunction

    function automatic int key(input int d, input logic [31:0] a);
        return d * 65536 + int'((a - BASE) >> 2);
    endfunction

    function automatic void push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    // Per-cycle output check of both instances against the scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit   ea, ee, have;
            exp_t h;
            ea = 1'b0; ee = 1'b0; have = 1'b0;
            if (d == 0 && q0.size() > 0 && q0[0].cyc == ncyc) begin h = q0.pop_front(); have = 1'b1; end
            if (d == 1 && q1.size() > 0 && q1[0].cyc == ncyc) begin h = q1.pop_front(); have = 1'b1; end
            if (have) begin
                ee = h.err;
                ea = !h.err;
                if (h.err)      exp_dat[d] = 32'h0;
                else if (h.upd) exp_dat[d] = h.dat;
            end
            chk($sformatf("ack dut%0d", d), 32'(out_ack(d)), 32'(ea));
            chk($sformatf("err dut%0d", d), 32'(out_err(d)), 32'(ee));
            chk($sformatf("dat dut%0d", d), out_dat(d), exp_dat[d]);
        end
    end

    // One complete master transfer; request fields are scrambled after the sample edge.
    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] dt,
                        input logic [3:0] s, input int hold, output logic [31:0] rd);
        int   n, e, k;
        bit   er;
        exp_t x;
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = dt; sel[d] = s;
        n  = ncyc + 1;
        e  = n + 1 + ws(d);
        er = m_err(a);
        x.cyc = e; x.err = er; x.upd = !er && !w; x.dat = 32'h0;
        if (!er) begin
            k = key(d, a);
            if (w) begin
                logic [31:0] cur;
                cur = mdl.exists(k) ? mdl[k] : 32'h0;
                for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = dt[8*b +: 8];
                mdl[k] = cur;
            end else begin
                x.dat = mdl[k];
            end
        end
        push(d, x);
        @(negedge clk);
        we[d] = ~w; adr[d] = a ^ 32'h4; wdat[d] = ~dt; sel[d] = ~s;
        repeat (e - ncyc) @(negedge clk);
        rd = out_dat(d);
        repeat (hold) @(negedge clk);
        cyc[d] = 1'b0; stb[d] = 1'b0;
    endtask

    // Read with cyc/stb held for h consecutive edges: a new sample every 3+ws cycles.
    task automatic stream(input int d, input logic [31:0] a, input int h);
        int   n;
        exp_t x;
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; adr[d] = a; sel[d] = 4'hF;
        n = ncyc + 1;
        for (int s = n; s <= n + h - 1; s += 3 + ws(d)) begin
            if (s + ws(d) <= n + h - 1) begin
                x.cyc = s + 1 + ws(d); x.err = 1'b0; x.upd = 1'b1; x.dat = mdl[key(d, a)];
                push(d, x);
            end
        end
        repeat (h) @(negedge clk);
        cyc[d] = 1'b0; stb[d] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        cyc = '0; stb = '0; we = '0; adr = '0; wdat = '0; sel = '0;
        exp_dat[0] = 32'h0; exp_dat[1] = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset dat0", rdat0, 32'h0);
        chk("reset ack/err0", {30'h0, ack0, err0}, 32'h0);
        chk("reset dat3", rdat1, 32'h0);
        rst_n = 1'b1;

        // Zero wait states: full write, read back, byte lanes.
        xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, r);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, r);
        chk("read 0x10", r, 32'hDEAD_BEEF);
        xfer(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0, r);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, r);
        chk("byte lanes 0x10", r, 32'hDE22_BE44);

        // Error terminations and protection of word 0.
        xfer(0, 1'b1, 32'h0, 32'hA5A5_0001, 4'hF, 0, r);
        xfer(0, 1'b0, 32'h13, 32'h0, 4'hF, 0, r);
        chk("misaligned dat", r, 32'h0);
        xfer(0, 1'b0, 32'h1000, 32'h0, 4'hF, 0, r);
        chk("range dat", r, 32'h0);
        xfer(0, 1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF, 0, r);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, r);
        chk("word0 kept", r, 32'hA5A5_0001);
        xfer(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 0, r);
        chk("wrap dat", r, 32'h0);

        // sel=0 write acks but changes nothing; sticky stb; back-to-back stream.
        xfer(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 0, r);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1, r);
        chk("sel0 write", r, 32'hDE22_BE44);
        xfer(0, 1'b1, 32'h14, 32'h0BAD_F00D, 4'hF, 0, r);
        xfer(0, 1'b0, 32'h14, 32'h0, 4'hF, 0, r);
        chk("raw 0x14", r, 32'h0BAD_F00D);
        stream(0, 32'h10, 8);

        // Three wait states: latency, abort in WAIT, error.
        xfer(1, 1'b1, 32'h20, 32'h0BAD_C0DE, 4'hF, 0, r);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, 0, r);
        chk("ws3 read 0x20", r, 32'h0BAD_C0DE);
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h20; wdat[1] = 32'h1234_5678; sel[1] = 4'hF;
        repeat (3) @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (2) @(negedge clk);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, 0, r);
        chk("abort kept 0x20", r, 32'h0BAD_C0DE);
        xfer(1, 1'b0, 32'h1004, 32'h0, 4'hF, 0, r);
        chk("ws3 range dat", r, 32'h0);
        stream(1, 32'h20, 10);

        // Asynchronous reset while a write sits in WAIT.
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h20; wdat[1] = 32'h7777_7777; sel[1] = 4'hF;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q0.delete(); q1.delete();
        exp_dat[0] = 32'h0; exp_dat[1] = 32'h0;
        #1;
        chk("async rst dat3", rdat1, 32'h0);
        chk("async rst ack/err3", {30'h0, ack1, err1}, 32'h0);
        chk("async rst dat0", rdat0, 32'h0);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, 0, r);
        chk("post-reset 0x20", r, 32'h0BAD_C0DE);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, r);
        chk("post-reset 0x10", r, 32'hDE22_BE44);

        repeat (4) @(negedge clk);
        chk("responses outstanding", 32'(q0.size() + q1.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
